// File: rtl/mux41.sv
// mux41: registered (or optionally combinational) 4-to-1 lane selector.
// Parameters: DATA_W lane/output width; OUT_REG 1 = registered y, 0 = combinational y.
// Ports: clk (rising edge), rst_n (async active-low, clears y),
//        a (4 lanes, lane k at a[k*DATA_W +: DATA_W]), s (select 0..3), y (selected lane).
module mux41 #(
  parameter int DATA_W  = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DATA_W-1:0] a,
  input  logic [1:0]          s,
  output logic [DATA_W-1:0]   y
);
  logic [DATA_W-1:0] lane [4];
  logic [DATA_W-1:0] y_d;
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign lane[k] = a[k*DATA_W +: DATA_W];
  end
  // Array indexing keeps an X/Z select visible as X rather than defaulting to a lane.
  assign y_d = lane[s];
  if (OUT_REG) begin : g_reg
    logic [DATA_W-1:0] y_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) y_q <= '0;
      else        y_q <= y_d;
    assign y = y_q;
  end else begin : g_comb
    assign y = y_d;
  end
endmodule

// File: tb/tb_mux41.sv
module tb_mux41;
  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [1:0] s;
  logic [0:0] y;
  int n_cmp = 0;
  int n_bad = 0;

  mux41 #(.DATA_W(1), .OUT_REG(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .s    (s),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [1:0] s;
    logic       exp;
    string      name;
  } vec_t;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: y=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vec_t tbl [12];
    tbl[0]  = '{4'b0001, 2'd0, 1'b1, "walk1_s0"};
    tbl[1]  = '{4'b0010, 2'd1, 1'b1, "walk1_s1"};
    tbl[2]  = '{4'b0100, 2'd2, 1'b1, "walk1_s2"};
    tbl[3]  = '{4'b1000, 2'd3, 1'b1, "walk1_s3"};
    tbl[4]  = '{4'b0000, 2'd0, 1'b0, "zero_s0"};
    tbl[5]  = '{4'b1110, 2'd0, 1'b0, "walk0_s0"};
    tbl[6]  = '{4'b1110, 2'd1, 1'b1, "walk0_s1"};
    tbl[7]  = '{4'b1110, 2'd2, 1'b1, "walk0_s2"};
    tbl[8]  = '{4'b1110, 2'd3, 1'b1, "walk0_s3"};
    tbl[9]  = '{4'b0111, 2'd3, 1'b0, "hole_s3"};
    tbl[10] = '{4'b1011, 2'd2, 1'b0, "hole_s2"};
    tbl[11] = '{4'b1101, 2'd1, 1'b0, "hole_s1"};

    rst_n = 1'b0;
    a = 4'b1111;
    s = 2'd0;
    #1 check("reset_init", y, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("reset_hold", y, 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_release", y, 1'b1);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a = tbl[i].a;
      s = tbl[i].s;
      @(posedge clk);
      #1 check(tbl[i].name, y, tbl[i].exp);
    end

    @(negedge clk);
    s = 2'd2;
    a = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check("isolation", y, 1'b0);
      @(negedge clk) a = (i % 2 == 0) ? 4'b1011 : 4'b0000;
    end

    @(negedge clk);
    a = 4'b1000;
    s = 2'd0;
    @(posedge clk);
    #1 check("latency_before", y, 1'b0);
    #2 s = 2'd3;
    #1 check("latency_midcycle", y, 1'b0);
    @(posedge clk);
    #1 check("latency_after", y, 1'b1);

    #2 rst_n = 1'b0;
    #1 check("async_reset_now", y, 1'b0);
    #1 rst_n = 1'b1;
    #1 check("async_reset_hold", y, 1'b0);
    @(posedge clk);
    #1 check("async_reset_resume", y, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
